// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: read FSM state encoding, default bus timing
// constants (also used by the write-path timing FSM) and the cycle-timer
// load helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEhU,
        StGap,
        StEhL,
        StHold,
        StDone
    } lcd_state_e;

    // Default timing at 50 MHz, in clock cycles.
    localparam int unsigned LcdSetupCyc = 2;    // RS/RW stable before E rises (>= 40 ns)
    localparam int unsigned LcdEHighCyc = 12;   // E high per nibble (>= 230 ns)
    localparam int unsigned LcdGapCyc   = 50;   // E low between nibbles (>= 1 us)
    localparam int unsigned LcdHoldCyc  = 1;    // RS/RW held after final E fall
    localparam int unsigned LcdPollMax  = 1000; // busy-flag reads before giving up

    localparam int unsigned CycCntW = 16;

    // Timer load value for a timed state; a zero-cycle setting still lasts one cycle.
    function automatic logic [CycCntW-1:0] cyc_load(input int unsigned cyc);
        logic [CycCntW-1:0] val;
        if (cyc == 0) begin
            val = CycCntW'(1);
        end else begin
            val = CycCntW'(cyc);
        end
        return val;
    endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request/response handshake and LCD pad signals of the bus reader.
// slave: the reader itself. master: requester plus LCD side.
interface lcd_bus_reader_if;

    logic       rd_req;
    logic       rd_rs;
    logic       SF_D11;
    logic       SF_D10;
    logic       SF_D9;
    logic       SF_D8;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       bus_owned;
    logic       busy;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       poll_timeout;

    modport slave (
        input  rd_req, rd_rs, SF_D11, SF_D10, SF_D9, SF_D8,
        output LCD_E, LCD_RS, LCD_RW, bus_owned, busy, rd_data, rd_valid, poll_timeout
    );

    modport master (
        output rd_req, rd_rs, SF_D11, SF_D10, SF_D9, SF_D8,
        input  LCD_E, LCD_RS, LCD_RW, bus_owned, busy, rd_data, rd_valid, poll_timeout
    );

endinterface

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter shared by all timed states of the LCD reader.
// done_o is high while the count sits at 1, i.e. during a state's last cycle.
module lcd_cycle_timer
    import lcd_pkg::*;
#(
    parameter int unsigned Width = CycCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [Width-1:0] count_q, count_d;

    // Next count: load wins, otherwise count down and park at 1.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q > Width'(1))) begin
            count_d = count_q - Width'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == Width'(1));

endmodule

// File: rtl/lcd_bus_reader.sv
// 4-bit read transaction engine for the character LCD bus. Returns the busy
// flag/address counter (RS=0) or a DDRAM/CGRAM byte (RS=1).
// Optional feature: define LCD_READER_POLL_EN to repeat RS=0 reads while the
// busy flag is set, up to POLL_MAX reads.
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = LcdSetupCyc,
    parameter int unsigned E_HIGH_CYC = LcdEHighCyc,
    parameter int unsigned GAP_CYC    = LcdGapCyc,
    parameter int unsigned HOLD_CYC   = LcdHoldCyc,
    parameter int unsigned POLL_MAX   = LcdPollMax
) (
    input  logic           clk,
    input  logic           reset,
    lcd_bus_reader_if.slave bus
);

    lcd_state_e         state_q, state_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic [3:0]         pad_nib;

    logic               tmr_load;
    logic [CycCntW-1:0] tmr_val;
    logic               tmr_en;
    logic               tmr_done;

`ifdef LCD_READER_POLL_EN
    localparam int unsigned PollW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;

    logic [PollW-1:0]   poll_cnt_q, poll_cnt_d;
    logic               timeout_q, timeout_d;
    logic               poll_again;

    // Another read is due while the busy flag is set and reads remain.
    assign poll_again = !rs_q && data_q[7] && ((32'(poll_cnt_q) + 32'd1) < POLL_MAX);
`else
    logic               unused_poll_max;
    assign unused_poll_max = (POLL_MAX == 0);
`endif

    assign pad_nib = {bus.SF_D11, bus.SF_D10, bus.SF_D9, bus.SF_D8};

    lcd_cycle_timer #(
        .Width (CycCntW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    // Next-state logic: sequence the timed states and capture nibbles on E's last cycle.
    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_val  = cyc_load(SETUP_CYC);
        tmr_en   = 1'b0;
`ifdef LCD_READER_POLL_EN
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.rd_req) begin
                    rs_d     = bus.rd_rs;
                    tmr_load = 1'b1;
                    tmr_val  = cyc_load(SETUP_CYC);
                    state_d  = StSetup;
`ifdef LCD_READER_POLL_EN
                    poll_cnt_d = '0;
                    timeout_d  = 1'b0;
`endif
                end
            end
            StSetup: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = cyc_load(E_HIGH_CYC);
                    state_d  = StEhU;
                end
            end
            StEhU: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    data_d[7:4] = pad_nib;
                    tmr_load    = 1'b1;
                    tmr_val     = cyc_load(GAP_CYC);
                    state_d     = StGap;
                end
            end
            StGap: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = cyc_load(E_HIGH_CYC);
                    state_d  = StEhL;
                end
            end
            StEhL: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    data_d[3:0] = pad_nib;
                    tmr_load    = 1'b1;
                    tmr_val     = cyc_load(HOLD_CYC);
                    state_d     = StHold;
                end
            end
            StHold: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
`ifdef LCD_READER_POLL_EN
                    if (poll_again) begin
                        tmr_load   = 1'b1;
                        tmr_val    = cyc_load(SETUP_CYC);
                        poll_cnt_d = poll_cnt_q + PollW'(1);
                        state_d    = StSetup;
                    end else begin
                        // Flag still set here means the read budget ran out.
                        timeout_d = !rs_q && data_q[7];
                        state_d   = StDone;
                    end
`else
                    state_d = StDone;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
`ifdef LCD_READER_POLL_EN
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
`ifdef LCD_READER_POLL_EN
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // Bus strobes decoded from state; RS/RW only change while E is low.
    always_comb begin
        bus.LCD_E        = 1'b0;
        bus.LCD_RS       = 1'b0;
        bus.LCD_RW       = 1'b0;
        bus.bus_owned    = 1'b0;
        bus.busy         = (state_q != StIdle);
        bus.rd_valid     = 1'b0;
        bus.poll_timeout = 1'b0;
        unique case (state_q)
            StSetup, StGap, StHold: begin
                bus.LCD_RS    = rs_q;
                bus.LCD_RW    = 1'b1;
                bus.bus_owned = 1'b1;
            end
            StEhU, StEhL: begin
                bus.LCD_E     = 1'b1;
                bus.LCD_RS    = rs_q;
                bus.LCD_RW    = 1'b1;
                bus.bus_owned = 1'b1;
            end
            StDone: begin
                bus.rd_valid = 1'b1;
`ifdef LCD_READER_POLL_EN
                bus.poll_timeout = timeout_q;
`endif
            end
            default: begin
                bus.LCD_E = 1'b0;
            end
        endcase
    end

    assign bus.rd_data = data_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader. The LCD side is modelled as a queue
// of nibbles advanced on every E falling edge; expected bytes and latencies
// come from the bus timing rules.
module tb_lcd_bus_reader;

    localparam int unsigned TbSetup   = 2;
    localparam int unsigned TbEHigh   = 12;
    localparam int unsigned TbGap     = 50;
    localparam int unsigned TbHold    = 1;
    localparam int unsigned TbPollMax = 4;
    localparam int TbLat = TbSetup + 2 * TbEHigh + TbGap + TbHold;

    logic clk = 1'b0;
    logic reset;

    lcd_bus_reader_if bus_if ();

    lcd_bus_reader #(
        .SETUP_CYC  (TbSetup),
        .E_HIGH_CYC (TbEHigh),
        .GAP_CYC    (TbGap),
        .HOLD_CYC   (TbHold),
        .POLL_MAX   (TbPollMax)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] bus_nib = 4'h0;
    logic [3:0] bus_q[$];

    assign bus_if.SF_D11 = bus_nib[3];
    assign bus_if.SF_D10 = bus_nib[2];
    assign bus_if.SF_D9  = bus_nib[1];
    assign bus_if.SF_D8  = bus_nib[0];

    // LCD model and protocol monitor.
    logic e_prev = 1'b0;
    logic rs_prev = 1'b0;
    logic rw_prev = 1'b0;
    int   e_len = 0;
    int   lo_len = 0;
    bit   had_fall = 1'b0;
    int   e_q[$];
    int   gap_q[$];
    int   valid_cnt = 0;
    int   e_falls = 0;

    always @(negedge clk) begin
        if (!e_prev && bus_if.LCD_E) begin
            checks++;
            assert ({bus_if.LCD_RS, bus_if.LCD_RW} === {rs_prev, rw_prev}) else begin
                errors++;
                $error("FAIL e_rise_rs_rw: observed %b%b expected %b%b",
                       bus_if.LCD_RS, bus_if.LCD_RW, rs_prev, rw_prev);
            end
            if (had_fall) gap_q.push_back(lo_len);
            e_len = 0;
        end
        if (rw_prev && !bus_if.LCD_RW) begin
            checks++;
            assert (e_prev === 1'b0) else begin
                errors++;
                $error("FAIL rw_fall_e_low: observed E=%b expected 0", e_prev);
            end
        end
        if (bus_if.LCD_E) e_len++;
        if (e_prev && !bus_if.LCD_E) begin
            e_q.push_back(e_len);
            e_falls++;
            had_fall = 1'b1;
            lo_len   = 0;
            if (bus_q.size() != 0) void'(bus_q.pop_front());
        end
        if (!bus_if.LCD_E) lo_len++;
        if (!bus_if.bus_owned) had_fall = 1'b0;
        if (bus_if.rd_valid) begin
            valid_cnt++;
            checks++;
            assert ({bus_if.LCD_RW, bus_if.bus_owned} === 2'b00) else begin
                errors++;
                $error("FAIL done_rw_owned: observed %b%b expected 00",
                       bus_if.LCD_RW, bus_if.bus_owned);
            end
        end
        bus_nib = (bus_q.size() != 0) ? bus_q[0] : 4'h0;
        e_prev  = bus_if.LCD_E;
        rs_prev = bus_if.LCD_RS;
        rw_prev = bus_if.LCD_RW;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_read(input logic rs);
        int n = 0;
        while (bus_if.busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_req", 32'(bus_if.busy), 32'd0);
        bus_if.rd_req = 1'b1;
        bus_if.rd_rs  = rs;
        @(negedge clk);
        bus_if.rd_req = 1'b0;
    endtask

    // Called one negedge after the accepting edge; lat counts those negedges.
    task automatic wait_valid(input int bound, input logic exp_rs, output int lat,
                              output bit rs_ok, output bit busy_ok);
        lat     = 1;
        rs_ok   = 1'b1;
        busy_ok = 1'b1;
        while (bus_if.rd_valid !== 1'b1 && lat < bound) begin
            if (bus_if.bus_owned && bus_if.LCD_RS !== exp_rs) rs_ok = 1'b0;
            if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("valid_seen", 32'(bus_if.rd_valid), 32'd1);
    endtask

    initial begin : watchdog
        #(200000 * 20);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         lat;
        bit         rs_ok;
        bit         busy_ok;
        int         vc0;
        int         ef0;
        int         n;
        int         t;
        int         stamp[3];
        logic [3:0] hi;
        logic [3:0] lo;
        logic       rs;
        logic [7:0] exp_b[3];

        reset         = 1'b0;
        bus_if.rd_req = 1'b0;
        bus_if.rd_rs  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_e", 32'(bus_if.LCD_E), 32'd0);
        check("rst_rs", 32'(bus_if.LCD_RS), 32'd0);
        check("rst_rw", 32'(bus_if.LCD_RW), 32'd0);
        check("rst_owned", 32'(bus_if.bus_owned), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_data", 32'(bus_if.rd_data), 32'd0);
        check("rst_valid", 32'(bus_if.rd_valid), 32'd0);
        check("rst_timeout", 32'(bus_if.poll_timeout), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed read: bus 0xB then 0x4, RS=1.
        bus_q = '{4'hB, 4'h4};
        e_q.delete();
        gap_q.delete();
        start_read(1'b1);
        wait_valid(500, 1'b1, lat, rs_ok, busy_ok);
        check("b4_latency", 32'(lat - 1), 32'(TbLat));
        check("b4_data", 32'(bus_if.rd_data), 32'hB4);
        check("b4_rs_held", 32'(rs_ok), 32'd1);
        check("b4_busy_held", 32'(busy_ok), 32'd1);
        check("b4_e_pulses", 32'(e_q.size()), 32'd2);
        check("b4_e_hi_u", 32'((e_q.size() > 0) ? e_q[0] : -1), 32'(TbEHigh));
        check("b4_e_hi_l", 32'((e_q.size() > 1) ? e_q[1] : -1), 32'(TbEHigh));
        check("b4_gaps", 32'(gap_q.size()), 32'd1);
        check("b4_gap_len", 32'((gap_q.size() > 0) ? gap_q[0] : -1), 32'(TbGap));

        // Random single reads against the nibble-queue model.
        repeat (4) begin
            rs = 1'($urandom_range(0, 1));
            hi = 4'($urandom);
            lo = 4'($urandom);
`ifdef LCD_READER_POLL_EN
            if (!rs) hi[3] = 1'b0;
`endif
            bus_q.push_back(hi);
            bus_q.push_back(lo);
            start_read(rs);
            wait_valid(500, rs, lat, rs_ok, busy_ok);
            check("rand_latency", 32'(lat - 1), 32'(TbLat));
            check("rand_data", 32'(bus_if.rd_data), 32'({hi, lo}));
            check("rand_rs_held", 32'(rs_ok), 32'd1);
            check("rand_timeout", 32'(bus_if.poll_timeout), 32'd0);
        end

        // Back-to-back reads with rd_req held high.
        n = 0;
        while (bus_if.busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            hi = 4'($urandom);
            lo = 4'($urandom);
            exp_b[i] = {hi, lo};
            bus_q.push_back(hi);
            bus_q.push_back(lo);
        end
        bus_if.rd_rs  = 1'b1;
        bus_if.rd_req = 1'b1;
        t = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (bus_if.rd_valid !== 1'b1 && n < 400) begin
                @(negedge clk);
                t++;
                n++;
            end
            check("b2b_valid", 32'(bus_if.rd_valid), 32'd1);
            check("b2b_data", 32'(bus_if.rd_data), 32'(exp_b[i]));
            check("b2b_rw_done", 32'(bus_if.LCD_RW), 32'd0);
            stamp[i] = t;
            if (i == 2) bus_if.rd_req = 1'b0;
            @(negedge clk);
            t++;
            check("b2b_idle_gap", 32'(bus_if.busy), 32'd0);
            if (i < 2) begin
                @(negedge clk);
                t++;
                check("b2b_next_setup", 32'(bus_if.bus_owned), 32'd1);
            end
        end
        check("b2b_period_1", 32'(stamp[1] - stamp[0]), 32'(TbLat + 2));
        check("b2b_period_2", 32'(stamp[2] - stamp[1]), 32'(TbLat + 2));

        // Reset asserted in the middle of GAP.
        bus_q.delete();
        bus_q = '{4'hA, 4'h5};
        ef0 = e_falls;
        start_read(1'b1);
        n = 0;
        while (e_falls == ef0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("gap_reached", 32'(e_falls - ef0), 32'd1);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstgap_e", 32'(bus_if.LCD_E), 32'd0);
        check("rstgap_rw", 32'(bus_if.LCD_RW), 32'd0);
        check("rstgap_owned", 32'(bus_if.bus_owned), 32'd0);
        check("rstgap_busy", 32'(bus_if.busy), 32'd0);
        check("rstgap_valid", 32'(bus_if.rd_valid), 32'd0);
        check("rstgap_data", 32'(bus_if.rd_data), 32'd0);
        reset = 1'b1;
        bus_q.delete();
        vc0 = valid_cnt;
        repeat (150) @(negedge clk);
        check("rstgap_no_valid", 32'(valid_cnt - vc0), 32'd0);
        check("rstgap_data_kept", 32'(bus_if.rd_data), 32'd0);

        // rd_req pulsed during the upper E strobe is ignored.
        hi = 4'($urandom);
        lo = 4'($urandom);
        bus_q.push_back(hi);
        bus_q.push_back(lo);
        vc0 = valid_cnt;
        start_read(1'b1);
        n = 0;
        while (bus_if.LCD_E !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ehu_reached", 32'(bus_if.LCD_E), 32'd1);
        bus_if.rd_req = 1'b1;
        bus_if.rd_rs  = 1'b0;
        @(negedge clk);
        bus_if.rd_req = 1'b0;
        wait_valid(500, 1'b1, lat, rs_ok, busy_ok);
        check("ehu_data", 32'(bus_if.rd_data), 32'({hi, lo}));
        check("ehu_rs_held", 32'(rs_ok), 32'd1);
        repeat (150) @(negedge clk);
        check("ehu_one_valid", 32'(valid_cnt - vc0), 32'd1);

`ifdef LCD_READER_POLL_EN
        // Busy flag set for three reads, then clear.
        bus_q = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h5};
        vc0 = valid_cnt;
        start_read(1'b0);
        wait_valid(2000, 1'b0, lat, rs_ok, busy_ok);
        check("poll_latency", 32'(lat - 1), 32'(4 * TbLat));
        check("poll_data", 32'(bus_if.rd_data), 32'h05);
        check("poll_no_timeout", 32'(bus_if.poll_timeout), 32'd0);
        check("poll_busy_held", 32'(busy_ok), 32'd1);
        repeat (120) @(negedge clk);
        check("poll_one_valid", 32'(valid_cnt - vc0), 32'd1);

        // Busy flag never clears: give up after the read budget.
        bus_q.delete();
        for (int i = 0; i < int'(TbPollMax); i++) begin
            bus_q.push_back(4'h8);
            bus_q.push_back(4'h0);
        end
        vc0 = valid_cnt;
        start_read(1'b0);
        wait_valid(2000, 1'b0, lat, rs_ok, busy_ok);
        check("tmo_latency", 32'(lat - 1), 32'(TbPollMax * TbLat));
        check("tmo_flag", 32'(bus_if.poll_timeout), 32'd1);
        check("tmo_data", 32'(bus_if.rd_data), 32'h80);
        check("tmo_busy_held", 32'(busy_ok), 32'd1);
        repeat (120) @(negedge clk);
        check("tmo_one_valid", 32'(valid_cnt - vc0), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
